reset_uart: RTL and testbench
=============================

RESET_UART -- requirements
Module: reset_uart

Interface
REQ-001 Parameter RESET_BYTE, default 8'hFF: the received byte value that requests a reset.
REQ-002 clk  input  1  system clock; the only clock. The block holds no state, so clk does not affect the output.
REQ-003 rst  output  1  reset request; synchronous, active-high; downstream logic samples it on the rising edge of clk.
REQ-004 rx_data_fresh  input  1  UART receiver strobe; high while rx_data holds a newly received byte.
REQ-005 rx_data  input  8  byte from the UART receiver; valid only while rx_data_fresh is high.
REQ-006 Port order is fixed as clk, rx_data_fresh, rx_data, rst, so positional instantiation works.

Function
REQ-007 rst SHALL equal rx_data_fresh AND (rx_data == RESET_BYTE).
- Purely combinational.
- No register stage and no pulse stretching.
REQ-008 rst SHALL rise in the same simulation time step as the qualifying rx_data_fresh rising edge.
- Zero clock latency; no wait for a clk edge.
REQ-009 rst SHALL fall in the same time step as whichever happens first:
- rx_data_fresh deasserts, or
- rx_data stops equalling RESET_BYTE.
- No hold-over to the next clk edge.
REQ-010 rst SHALL stay low for any rx_data value other than RESET_BYTE, whatever the state of rx_data_fresh.
- Boundary values 8'hFE and 8'h7F SHALL NOT trigger.
REQ-011 rst SHALL stay low while rx_data_fresh is low, even when rx_data == RESET_BYTE.
- A stale byte does not trigger.
REQ-012 If rx_data_fresh stays high across several clk edges with RESET_BYTE present, rst SHALL stay high for that whole interval.
REQ-013 If rx_data changes while rx_data_fresh is high, rst SHALL follow the comparison immediately.
REQ-014 rst pulse width equals the overlap of rx_data_fresh high and the RESET_BYTE match.
- Callers needing a minimum width extend it externally.
REQ-015 The equality compare SHALL use all 8 bits.
- With the default parameter, the compare reduces to the AND of all rx_data bits.
REQ-016 No latches, no internal state, no dependence on clk.

Reset
REQ-017 The block has no reset input and no state; it needs no initialization.
REQ-018 With X or Z on rx_data_fresh or rx_data, rst follows normal gate X-propagation.
- rst SHALL be 0 whenever rx_data_fresh is a known 0.
REQ-019 rst is the reset source for the rest of the system. It SHALL NOT be fed back into this block.

Verification
REQ-020 clk period 10. rx_data=8'hFF at t=5; rx_data_fresh 0->1 at t=10.
- rst = 1 at the t=10 edge and at t=14.
REQ-021 From REQ-020, rx_data_fresh 1->0 at t=18.
- rst = 0 at t=19, after the t=15 clk edge.
- rst stays 0 through t=25.
REQ-022 rx_data=8'hFE, rx_data_fresh=1 for 3 clk cycles.
- rst = 0 throughout.
REQ-023 rx_data=8'hFF, rx_data_fresh held 0.
- rst = 0 throughout.
REQ-024 rx_data_fresh=1 with rx_data stepping 8'h00 -> 8'hFF -> 8'h00.
- rst follows 0 -> 1 -> 0 with zero delay at each step.
REQ-025 Instantiate with RESET_BYTE=8'hA5; drive rx_data=8'hA5 with fresh=1, then 8'hFF with fresh=1.
- rst = 1 for 8'hA5.
- rst = 0 for 8'hFF.

Source files
------------

// File: rtl/reset_uart_if.sv
// Receive-side bundle between a UART receiver and the reset decoder.
// The master drives the received byte and its strobe, and the slave returns the reset request.
interface reset_uart_if;
  logic       rx_data_fresh;
  logic [7:0] rx_data;
  logic       rst;

  modport master (
    output rx_data_fresh,
    output rx_data,
    input  rst
  );

  modport slave (
    input  rx_data_fresh,
    input  rx_data,
    output rst
  );
endinterface

// File: rtl/reset_uart.sv
// Decodes a magic byte from a UART receiver into a system reset request.
// The block is purely combinational, so rst tracks the inputs with zero clock latency.
module reset_uart #(
  parameter logic [7:0] RESET_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       rx_data_fresh,
  input  logic [7:0] rx_data,
  output logic       rst
);

  // clk exists only to keep the positional port list stable for existing instantiations.
  logic unused_clk;
  assign unused_clk = clk;

  // NOTE: a continuous assign covers every input combination, so no latch can be inferred,
  // and when the strobe is a known 0 the AND holds rst at 0 even if rx_data is X.
  assign rst = rx_data_fresh & (rx_data == RESET_BYTE);

endmodule

// File: tb/tb_reset_uart.sv
// Scoreboarded, table-driven bench for reset_uart with the default and the 8'hA5 magic byte.
module tb_reset_uart;
  logic clk;
  int   checks = 0;
  int   errors = 0;

  reset_uart_if dflt_if ();
  reset_uart_if a5_if ();

  reset_uart dut_dflt (
    .clk           (clk),
    .rx_data_fresh (dflt_if.rx_data_fresh),
    .rx_data       (dflt_if.rx_data),
    .rst           (dflt_if.rst)
  );

  reset_uart #(.RESET_BYTE(8'hA5)) dut_a5 (
    .clk           (clk),
    .rx_data_fresh (a5_if.rx_data_fresh),
    .rx_data       (a5_if.rx_data),
    .rst           (a5_if.rst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit         sel_a5;
    logic       fresh;
    logic [7:0] data;
    logic       exp_rst;
    string      name;
  } vec_t;

  typedef struct {
    string name;
    logic  exp;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: rst got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_rst(input string name, input logic exp);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic drive(input bit sel_a5, input logic f, input logic [7:0] d,
                       input logic exp, input string name);
    if (sel_a5) begin
      a5_if.rx_data_fresh = f;
      a5_if.rx_data       = d;
    end else begin
      dflt_if.rx_data_fresh = f;
      dflt_if.rx_data       = d;
    end
    expect_rst(name, exp);
  endtask

  task automatic compare(input bit sel_a5);
    exp_t e;
    logic act;
    act = sel_a5 ? a5_if.rst : dflt_if.rst;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", act, 1'bx);
    end else begin
      e = sb_q.pop_front();
      check(e.name, act, e.exp);
    end
  endtask

  initial begin
    // Expected values are derived independently: rst = fresh && (data == magic byte).
    vecs.push_back('{0, 1'b0, 8'h00, 1'b0, "idle_zero"});
    vecs.push_back('{0, 1'b1, 8'h00, 1'b0, "step_00"});
    vecs.push_back('{0, 1'b1, 8'hFF, 1'b1, "step_ff"});
    vecs.push_back('{0, 1'b1, 8'h00, 1'b0, "step_back_00"});
    vecs.push_back('{0, 1'b1, 8'hFE, 1'b0, "boundary_fe"});
    vecs.push_back('{0, 1'b1, 8'h7F, 1'b0, "boundary_7f"});
    vecs.push_back('{0, 1'b0, 8'hFF, 1'b0, "stale_ff"});
    vecs.push_back('{0, 1'b1, 8'hA5, 1'b0, "dflt_a5"});
    vecs.push_back('{1, 1'b1, 8'hA5, 1'b1, "a5_match"});
    vecs.push_back('{1, 1'b1, 8'hFF, 1'b0, "a5_ff"});
    vecs.push_back('{1, 1'b0, 8'hA5, 1'b0, "a5_stale"});
    vecs.push_back('{1, 1'b1, 8'hA4, 1'b0, "a5_a4"});
    vecs.push_back('{1, 1'b1, 8'h25, 1'b0, "a5_25"});

    dflt_if.rx_data_fresh = 1'b0;
    dflt_if.rx_data       = 8'h00;
    a5_if.rx_data_fresh   = 1'b0;
    a5_if.rx_data         = 8'h00;

    // Timed reference sequence: rise at t=10, fall at t=18.
    #5 drive(0, 1'b0, 8'hFF, 1'b0, "t5_stale");
    #1 compare(0);
    #4 drive(0, 1'b1, 8'hFF, 1'b1, "t10_rise");
    #1 compare(0);
    #3 expect_rst("t14_high", 1'b1);
    compare(0);
    #4 drive(0, 1'b0, 8'hFF, 1'b0, "t18_fall");
    #1 compare(0);
    #5 expect_rst("t24_low", 1'b0);
    compare(0);

    // Table vectors are driven two units after a rising edge and sampled before the next edge.
    foreach (vecs[i]) begin
      @(posedge clk);
      #2 drive(vecs[i].sel_a5, vecs[i].fresh, vecs[i].data, vecs[i].exp_rst, vecs[i].name);
      #1 compare(vecs[i].sel_a5);
    end

    // Hold the magic byte across several clock edges.
    @(posedge clk);
    #2 drive(0, 1'b1, 8'hFF, 1'b1, "hold_c0");
    #1 compare(0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      expect_rst($sformatf("hold_c%0d", c + 1), 1'b1);
      compare(0);
    end

    // Change the data mid-strobe, and rst must drop without waiting for an edge.
    #1 drive(0, 1'b1, 8'hEF, 1'b0, "mid_strobe_change");
    #1 compare(0);

    // Near-miss byte held for three cycles.
    @(posedge clk);
    #2 drive(0, 1'b1, 8'hFE, 1'b0, "fe_c0");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      compare(0);
      if (c < 2) expect_rst($sformatf("fe_c%0d", c + 1), 1'b0);
    end

    // Stale magic byte held for three cycles.
    @(posedge clk);
    #2 drive(0, 1'b0, 8'hFF, 1'b0, "stale_c0");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      compare(0);
      if (c < 2) expect_rst($sformatf("stale_c%0d", c + 1), 1'b0);
    end

    // Each single cleared bit must break the full 8-bit compare.
    for (int b = 0; b < 8; b++) begin
      logic [7:0] d;
      d = 8'hFF;
      d[b] = 1'b0;
      @(posedge clk);
      #2 drive(0, 1'b1, d, 1'b0, $sformatf("bit%0d_clear", b));
      #1 compare(0);
    end

    // An unknown byte with a known-low strobe must still give rst = 0.
    @(posedge clk);
    #2 drive(0, 1'b0, 8'hxx, 1'b0, "x_data_fresh0");
    #1 compare(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
